// File: rtl/register_port_arbiter.sv
// Arbitrates the register block's write port and read port 2 between the core and a debug port.
// Define REGARB_CLEAR_EN to build the post-reset sequencer that zeroes every register.
module register_port_arbiter #(
  parameter int ADDR_W       = 3,
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              coreRegWrite,
  input  logic [ADDR_W-1:0] coreWriteReg,
  input  logic [DATA_W-1:0] coreWriteData,
  input  logic [ADDR_W-1:0] coreReadReg1,
  input  logic [ADDR_W-1:0] coreReadReg2,
  input  logic              coreIdle,
  output logic              coreStall,
  output logic [DATA_W-1:0] coreReadData1,
  output logic [DATA_W-1:0] coreReadData2,
  input  logic              dbgReq,
  input  logic              dbgWe,
  input  logic [ADDR_W-1:0] dbgAddr,
  input  logic [DATA_W-1:0] dbgWdata,
  output logic              dbgAck,
  output logic [DATA_W-1:0] dbgRdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rfReadReg1,
  output logic [ADDR_W-1:0] rfReadReg2,
  output logic [ADDR_W-1:0] rfWriteReg,
  output logic              rfRegWrite,
  output logic [DATA_W-1:0] rfWriteData,
  input  logic [DATA_W-1:0] rfReadData1,
  input  logic [DATA_W-1:0] rfReadData2,
  output logic [1:0]        fsmState
);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGARB_CLEAR_EN
  localparam logic [1:0] RESET_STATE = CLEAR;
`else
  localparam logic [1:0] RESET_STATE = RUN;
`endif

  logic [1:0]        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [ADDR_W-1:0] clear_idx;
  logic              grant, forced, in_clear, rf_we;

  // Debug handshake: dbgReq is held, with dbgWe/dbgAddr/dbgWdata stable, until the
  // one-cycle dbgAck; the transfer itself happens in the grant cycle just before it.
  assign grant    = (state_q == RUN) && dbgReq &&
                    (coreIdle || (wait_cnt_q == 4'(STARVE_LIMIT)));
  assign forced   = grant && !coreIdle;
  assign in_clear = (state_q == CLEAR);
  assign dbgRdata = dbg_rdata_q;
  assign dbgAck   = (state_q == ACK);
  assign fsmState = state_q;
  assign coreReadData1 = rfReadData1;

`ifdef REGARB_CLEAR_EN
  logic [ADDR_W-1:0] index_q, index_d;
  assign clear_idx = index_q;
  assign busy      = in_clear;

  always_comb begin
    index_d = index_q;
    if (in_clear) index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) index_q <= '0;
    else         index_q <= index_d;
  end
`else
  assign clear_idx = LAST_IDX;
  assign busy      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      CLEAR: begin
`ifdef REGARB_CLEAR_EN
        if (clear_idx == LAST_IDX) state_d = RUN;
`else
        state_d = RUN;
`endif
      end
      RUN: begin
        if (grant) begin
          state_d = ACK;
          if (!dbgWe) dbg_rdata_d = rfReadData2;
        end
      end
      ACK:     state_d = RUN;
      default: state_d = RESET_STATE;
    endcase
    // The wait counter only advances while a request is stuck behind a busy core.
    if (!dbgReq || grant)
      wait_cnt_d = '0;
    else if ((state_q == RUN) && (wait_cnt_q < 4'(STARVE_LIMIT)))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_comb begin
    rf_we         = coreRegWrite;
    rfWriteReg    = coreWriteReg;
    rfWriteData   = coreWriteData;
    rfReadReg1    = coreReadReg1;
    rfReadReg2    = coreReadReg2;
    coreStall     = forced;
    coreReadData2 = rfReadData2;
    if (in_clear) begin
      rf_we       = 1'b1;
      rfWriteReg  = clear_idx;
      rfWriteData = '0;
      coreStall   = 1'b1;
    end else if (grant) begin
      rfReadReg2  = dbgAddr;
      rf_we       = dbgWe;
      rfWriteReg  = dbgAddr;
      rfWriteData = dbgWdata;
      if (!dbgWe) coreReadData2 = '0;
    end
    // Gated by reset so an aborted clear or grant never commits a write.
    rfRegWrite = rf_we & nReset;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= RESET_STATE;
      wait_cnt_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

endmodule
